// File: rtl/input_handle.sv
// -----------------------------------------------------------------------------
// input_handle
//
// Purpose
//   Assembles a code of CODE_LEN hexadecimal digits from a stream of
//   qualified digit samples. Each accepted digit is shifted into the low
//   nibble and older digits move up one nibble. When the buffer is full,
//   the first digit entered is in the most significant nibble.
//
//   Once CODE_LEN digits are held, further digits are ignored. The buffer
//   does not wrap and does not overwrite the oldest digit. A submit pulse
//   clears the buffer so that a new code can be entered. If submit and
//   digit_valid are high on the same edge, submit wins.
//
// Parameters
//   CODE_LEN      number of 4-bit digits in one code (legal range 1..8)
//
// Ports
//   clk           system clock; all state changes on its rising edge
//   rst_n         asynchronous active-low reset
//   digit_valid   qualifies digit_in; level-sampled on every rising edge
//   digit_in      digit value (0x0..0xF); ignored while digit_valid is low
//   submit        clears the code buffer and the digit count
//   entered_code  assembled code, right-aligned while partially entered
//   full          registered flag, high when CODE_LEN digits are held
//   ready         high when another digit can be accepted (always !full)
// -----------------------------------------------------------------------------
module input_handle #(
   parameter int CODE_LEN = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  digit_valid,
   input  logic [3:0]            digit_in,
   input  logic                  submit,
   output logic [4*CODE_LEN-1:0] entered_code,
   output logic                  full,
   output logic                  ready
);

   localparam int              CODE_W = 4 * CODE_LEN;
   localparam int              CNT_W  = $clog2(CODE_LEN + 1);
   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CODE_LEN);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [CODE_W-1:0] code_p0;
   logic [CNT_W-1:0]  cnt_p0;
   logic              full_p0;

   logic              accept;
   logic [CODE_W-1:0] code_shift;
   logic [CNT_W-1:0]  cnt_inc;

   // A digit is taken only when room remains and no clear is requested
   // on the same edge.
   assign accept  = digit_valid && !submit && (cnt_p0 < LEN_C);
   assign cnt_inc = cnt_p0 + ONE_C;

   // With a single-digit code there are no older nibbles to shift up, so
   // the new digit simply replaces the register contents.
   generate
      if (CODE_LEN == 1) begin : g_single
         assign code_shift = digit_in;
      end else begin : g_multi
         assign code_shift = {code_p0[CODE_W-5:0], digit_in};
      end
   endgenerate

   // ---- stage p0: code buffer, digit count and full flag ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_p0 <= '0;
         cnt_p0  <= '0;
         full_p0 <= 1'b0;
      end else if (submit) begin
         code_p0 <= '0;
         cnt_p0  <= '0;
         full_p0 <= 1'b0;
      end else if (accept) begin
         code_p0 <= code_shift;
         cnt_p0  <= cnt_inc;
         // full is set on the same edge that accepts the last digit.
         full_p0 <= (cnt_inc == LEN_C);
      end
   end

   assign entered_code = code_p0;
   assign full         = full_p0;
   assign ready        = !full_p0;

endmodule

// File: tb/tb_input_handle.sv
module tb_input_handle;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dv, sub;
   logic [3:0]  din;
   logic [15:0] code;
   logic        full, ready;

   logic        dv2, sub2;
   logic [3:0]  din2;
   logic [7:0]  code2;
   logic        full2, ready2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   input_handle #(.CODE_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .digit_valid(dv), .digit_in(din),
      .submit(sub), .entered_code(code), .full(full), .ready(ready)
   );

   input_handle #(.CODE_LEN(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .digit_valid(dv2), .digit_in(din2),
      .submit(sub2), .entered_code(code2), .full(full2), .ready(ready2)
   );

   typedef struct {
      logic        s;
      logic        v;
      logic [3:0]  d;
      logic [15:0] c;
      logic        f;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic s, input logic v, input logic [3:0] d,
                       input logic [15:0] c, input logic f);
      vec_t e;
      e.s = s; e.v = v; e.d = d; e.c = c; e.f = f;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input int c, input int f);
      check({name, " code"}, int'(code), c);
      check({name, " full"}, int'(full), f);
      check({name, " ready"}, int'(ready), (f == 0) ? 1 : 0);
   endtask

   task automatic step(input logic s, input logic v, input logic [3:0] d);
      sub = s; dv = v; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic s, input logic v, input logic [3:0] d);
      sub2 = s; dv2 = v; din2 = d;
      @(posedge clk);
      #1;
   endtask

   // Reference: the code is the list of accepted digits read as a base-16 number.
   int q[$];

   function automatic int model_code();
      int m = 0;
      foreach (q[i]) m = m * 16 + q[i];
      return m;
   endfunction

   initial begin
      rst_n = 1'b0;
      dv = 0; sub = 0; din = 0;
      dv2 = 0; sub2 = 0; din2 = 0;

      // 4-digit entry with idle gaps, full-hold, submit, re-entry.
      addv(0,1,4'h1,16'h0001,0); addv(0,0,4'hF,16'h0001,0);
      addv(0,1,4'h2,16'h0012,0); addv(0,0,4'h9,16'h0012,0);
      addv(0,1,4'h3,16'h0123,0); addv(0,0,4'h0,16'h0123,0);
      addv(0,1,4'h4,16'h1234,1); addv(0,1,4'h5,16'h1234,1);
      addv(0,0,4'h0,16'h1234,1); addv(1,0,4'h0,16'h0000,0);
      addv(0,1,4'hA,16'h000A,0); addv(0,1,4'hB,16'h00AB,0);
      addv(0,1,4'hC,16'h0ABC,0); addv(0,1,4'hD,16'hABCD,1);
      addv(1,1,4'hE,16'h0000,0); addv(1,0,4'h0,16'h0000,0);
      // Held valid, then held valid with submit on the third cycle.
      addv(0,1,4'h7,16'h0007,0); addv(0,1,4'h7,16'h0077,0);
      addv(0,1,4'h7,16'h0777,0); addv(1,0,4'h0,16'h0000,0);
      addv(0,1,4'h7,16'h0007,0); addv(0,1,4'h7,16'h0077,0);
      addv(1,1,4'h7,16'h0000,0); addv(0,0,4'h3,16'h0000,0);

      #12;
      check_all("reset", 0, 0);
      check("reset code2", int'(code2), 0);
      check("reset ready2", int'(ready2), 1);
      #10 rst_n = 1'b1;   // released between edges; the first row accepts on the next edge

      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].v, tbl[i].d);
         check_all($sformatf("vec%0d", i), int'(tbl[i].c), int'(tbl[i].f));
      end

      // Asynchronous reset mid-entry.
      step(0,1,4'h1); step(0,1,4'h2);
      check_all("pre-rst", 16'h0012, 0);
      #2 rst_n = 1'b0;
      #1 check_all("async rst", 0, 0);
      #2 rst_n = 1'b1;
      step(0,1,4'h9);
      check_all("post-rst 9", 16'h0009, 0);
      step(0,1,4'h8); step(0,1,4'h7);
      check_all("post-rst 3dig", 16'h0987, 0);
      step(0,1,4'h6);
      check_all("post-rst full", 16'h9876, 1);
      step(1,0,4'h0);
      check_all("post-rst clr", 0, 0);

      // Two-digit instance.
      step2(0,1,4'h3);
      check("len2 d1 code", int'(code2), 8'h03);
      check("len2 d1 full", int'(full2), 0);
      step2(0,1,4'h4);
      check("len2 d2 code", int'(code2), 8'h34);
      check("len2 d2 full", int'(full2), 1);
      check("len2 d2 ready", int'(ready2), 0);
      step2(0,1,4'h5);
      check("len2 d3 code", int'(code2), 8'h34);
      check("len2 d3 full", int'(full2), 1);
      step2(0,0,4'h0);

      // Randomized traffic against the digit-list model.
      q.delete();
      for (int n = 0; n < 400; n++) begin
         logic s, v;
         logic [3:0] d;
         s = ($urandom_range(0, 99) < 8);
         v = ($urandom_range(0, 99) < 60);
         d = 4'($urandom_range(0, 15));
         step(s, v, d);
         if (s) q.delete();
         else if (v && q.size() < 4) q.push_back(int'(d));
         check_all($sformatf("rnd%0d", n), model_code(), (q.size() == 4) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
